// File: rtl/wb_intercon.sv
// rtl/wb_intercon.sv - parametrised shared-bus Wishbone interconnect (N masters, M slaves)
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i/m_we_i    flattened master request fields
//   m_cyc_i/m_stb_i                   per-master cycle and strobe
//   m_dat_o                           read data broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o           per-master responses (granted master only)
//   s_adr_o/s_dat_o/s_sel_o/s_we_o    shared slave request fields
//   s_cyc_o/s_stb_o                   per-slave cycle and strobe (decoded, one-hot)
//   s_dat_i/s_ack_i/s_err_i/s_rty_i   flattened slave read data and responses
module wb_intercon #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'h0}},
    parameter int TIMEOUT = 255,
    parameter int ARB_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i,
    input  logic [NUM_SLAVES-1:0]     s_err_i,
    input  logic [NUM_SLAVES-1:0]     s_rty_i
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Wide enough to hold the value TIMEOUT itself
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [MW-1:0]   grant;
    logic [MW-1:0]   ptr;
    logic [TW-1:0]   tcnt;
    logic            unmapped_err;

    // Arbitration
    logic [MW-1:0]   next_grant;
    logic            found;
    int              arb_idx;

    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        arb_idx    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            arb_idx = (ARB_MODE == 0) ? (int'(ptr) + i) % NUM_MASTERS : i;
            if (!found && m_cyc_i[arb_idx[MW-1:0]]) begin
                found      = 1'b1;
                next_grant = arb_idx[MW-1:0];
            end
        end
    end

    // Granted master's request, zero when idle
    logic busy, g_cyc, g_stb;

    assign busy    = (state == BUSY);
    assign g_cyc   = busy & m_cyc_i[grant];
    assign g_stb   = g_cyc & m_stb_i[grant];
    assign s_adr_o = busy ? m_adr_i[grant*32 +: 32] : 32'h0;
    assign s_dat_o = busy ? m_dat_i[grant*32 +: 32] : 32'h0;
    assign s_sel_o = busy ? m_sel_i[grant*4 +: 4] : 4'h0;
    assign s_we_o  = busy & m_we_i[grant];

    // Address decode: lowest matching slave wins on overlap
    logic [NUM_SLAVES-1:0] sel_oh;
    logic [SW-1:0]         sel_idx;
    logic                  sel_valid;

    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!sel_valid &&
                ((s_adr_o & SLAVE_MASK[32*k +: 32]) ==
                 (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32]))) begin
                sel_valid  = 1'b1;
                sel_idx    = SW'(k);
                sel_oh[k]  = 1'b1;
            end
        end
    end

    // Responses from the selected slave
    logic r_ack, r_err, r_rty, resp_any, expire;

    assign r_ack    = g_cyc & sel_valid & s_ack_i[sel_idx];
    assign r_err    = g_cyc & sel_valid & s_err_i[sel_idx];
    assign r_rty    = g_cyc & sel_valid & s_rty_i[sel_idx];
    assign resp_any = r_ack | r_err | r_rty;
    // Expiry depends only on registered state so the forced strobe drop
    // never forms a loop through a combinational slave response.
    assign expire   = (TIMEOUT > 0) && g_stb && sel_valid && (tcnt == TW'(TIMEOUT));

    assign s_cyc_o = g_cyc ? sel_oh : '0;
    assign s_stb_o = (g_stb && !expire) ? sel_oh : '0;
    assign m_dat_o = (busy && sel_valid) ? s_dat_i[sel_idx*32 +: 32] : 32'h0;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            m_ack_o[grant] = r_ack;
            m_err_o[grant] = r_err | unmapped_err | (expire & ~resp_any);
            m_rty_o[grant] = r_rty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= '0;
            tcnt         <= '0;
            unmapped_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt         <= '0;
                    unmapped_err <= 1'b0;
                    if (found) begin
                        grant <= next_grant;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[grant]) begin
                        state        <= IDLE;
                        tcnt         <= '0;
                        unmapped_err <= 1'b0;
                        if (ARB_MODE == 0)
                            ptr <= (int'(grant) == NUM_MASTERS - 1) ? '0 : grant + 1'b1;
                    end else begin
                        // Alternates so a held strobe sees one err per strobe
                        unmapped_err <= g_stb & ~sel_valid & ~unmapped_err;
                        if (g_stb && sel_valid && !resp_any && !expire)
                            tcnt <= tcnt + 1'b1;
                        else
                            tcnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_intercon.sv
// tb/tb_wb_intercon.sv - self-checking bench for wb_intercon
module tb_wb_intercon;
    localparam logic [127:0] BASE = {32'hF0010000, 32'hF0000000, 32'h00000000, 32'h40000000};
    localparam logic [127:0] MASK = {32'hFFFF0000, 32'hFFFF0000, 32'hFFFE0000, 32'hE0000000};

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [1:0][63:0]  m_adr, m_dat;
    logic [1:0][7:0]   m_sel;
    logic [1:0][1:0]   m_we, m_cyc, m_stb, m_ack, m_err, m_rty;
    logic [1:0][31:0]  m_rd, s_adr, s_wd;
    logic [1:0][3:0]   s_sel, s_cyc, s_stb, s_ack, ack_q;
    logic [1:0]        s_we;
    logic [1:0][127:0] s_rd;
    logic [3:0]        mute;
    logic              force_ack;

    wb_intercon #(.NUM_MASTERS(2), .NUM_SLAVES(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                  .TIMEOUT(8), .ARB_MODE(0)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr[0]), .m_dat_i(m_dat[0]), .m_sel_i(m_sel[0]), .m_we_i(m_we[0]),
        .m_cyc_i(m_cyc[0]), .m_stb_i(m_stb[0]), .m_dat_o(m_rd[0]),
        .m_ack_o(m_ack[0]), .m_err_o(m_err[0]), .m_rty_o(m_rty[0]),
        .s_adr_o(s_adr[0]), .s_dat_o(s_wd[0]), .s_sel_o(s_sel[0]), .s_we_o(s_we[0]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_dat_i(s_rd[0]),
        .s_ack_i(s_ack[0]), .s_err_i(4'h0), .s_rty_i(4'h0));

    wb_intercon #(.NUM_MASTERS(2), .NUM_SLAVES(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                  .TIMEOUT(8), .ARB_MODE(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr[1]), .m_dat_i(m_dat[1]), .m_sel_i(m_sel[1]), .m_we_i(m_we[1]),
        .m_cyc_i(m_cyc[1]), .m_stb_i(m_stb[1]), .m_dat_o(m_rd[1]),
        .m_ack_o(m_ack[1]), .m_err_o(m_err[1]), .m_rty_o(m_rty[1]),
        .s_adr_o(s_adr[1]), .s_dat_o(s_wd[1]), .s_sel_o(s_sel[1]), .s_we_o(s_we[1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_dat_i(s_rd[1]),
        .s_ack_i(s_ack[1]), .s_err_i(4'h0), .s_rty_i(4'h0));

    function automatic logic [31:0] slave_data(int k, logic [31:0] a);
        if (k == 1 && a == 32'h10) return 32'hDEADBEEF;
        return a ^ 32'hA5A50000 ^ (32'(k) * 32'h01010101);
    endfunction

    // Slaves: ack one cycle after the strobe is first seen (one wait state)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ack_q <= '0;
        else for (int d = 0; d < 2; d++) ack_q[d] <= s_stb[d] & ~ack_q[d] & ~mute;
    end

    always_comb begin
        s_rd  = '0;
        s_ack = '0;
        for (int d = 0; d < 2; d++) begin
            s_ack[d] = ack_q[d] | (force_ack ? 4'b0100 : 4'b0000);
            for (int k = 0; k < 4; k++) s_rd[d][32*k +: 32] = slave_data(k, s_adr[d]);
        end
    end

    // Reference decode from the address map
    logic [31:0] rbase [4] = '{32'h40000000, 32'h00000000, 32'hF0000000, 32'hF0010000};
    logic [31:0] rmask [4] = '{32'hE0000000, 32'hFFFE0000, 32'hFFFF0000, 32'hFFFF0000};

    function automatic int ref_decode(logic [31:0] a);
        for (int k = 0; k < 4; k++) if ((a & rmask[k]) == rbase[k]) return k;
        return -1;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic xfer(input int d, input int m, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, output logic ack, output logic err,
                        output logic [3:0] stbs, output logic [31:0] rd,
                        output logic [31:0] wsd, output logic wwe, output int ncyc);
        ack = 0; err = 0; stbs = 0; rd = 0; wsd = 0; wwe = 0; ncyc = 0;
        m_adr[d][32*m +: 32] = a;
        m_dat[d][32*m +: 32] = wd;
        m_sel[d][4*m +: 4]   = 4'hF;
        m_we[d][m]  = we;
        m_cyc[d][m] = 1'b1;
        m_stb[d][m] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            ncyc++;
            stbs |= s_stb[d];
            if (s_stb[d] != 0) begin wsd = s_wd[d]; wwe = s_we[d]; end
            if (m_ack[d][m] || m_err[d][m]) begin
                ack = m_ack[d][m]; err = m_err[d][m]; rd = m_rd[d];
                break;
            end
        end
        m_cyc[d][m] = 1'b0;
        m_stb[d][m] = 1'b0;
        m_we[d][m]  = 1'b0;
        tick();
    endtask

    typedef struct {
        int          m;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wd;
        int          slv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, err, wwe;
        logic [3:0] stbs;
        logic [31:0] rd, wsd, a, wd;
        int ncyc, k, m, bad, beats;
        int order [2][$];

        vecs[0] = '{0, 32'h00000010, 1'b0, 32'h0,        1,  32'hDEADBEEF};
        vecs[1] = '{1, 32'h40001234, 1'b1, 32'h12345678, 0,  32'hE5A51234};
        vecs[2] = '{0, 32'h5FFFFFFC, 1'b0, 32'h0,        0,  32'hFA5AFFFC};
        vecs[3] = '{1, 32'h0001FFFC, 1'b0, 32'h0,        1,  32'hA4A5FEFD};
        vecs[4] = '{0, 32'h00020000, 1'b0, 32'h0,        -1, 32'h0};
        vecs[5] = '{0, 32'hF0000004, 1'b0, 32'h0,        2,  32'h57A70206};
        vecs[6] = '{1, 32'hF0010008, 1'b1, 32'hCAFEF00D, 3,  32'h56A7030B};
        vecs[7] = '{0, 32'h80000000, 1'b0, 32'h0,        -1, 32'h0};
        vecs[8] = '{1, 32'hF0020000, 1'b0, 32'h0,        -1, 32'h0};
        vecs[9] = '{0, 32'h20000000, 1'b0, 32'h0,        -1, 32'h0};

        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        mute = '0; force_ack = 1'b0;
        do_reset();

        // Reset state
        chk("reset s_cyc/s_stb", {24'h0, s_cyc[0], s_stb[0]}, 32'h0);
        chk("reset m_ack/err/rty", {26'h0, m_ack[0], m_err[0], m_rty[0]}, 32'h0);
        chk("reset m_dat_o", m_rd[0], 32'h0);
        chk("reset s_adr_o", s_adr[0], 32'h0);
        chk("reset s_dat/sel/we", s_wd[0] | {27'h0, s_sel[0], s_we[0]}, 32'h0);

        // Arbitration latency: no slave cycle in the request cycle
        m_adr[0][31:0] = 32'h10; m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        #1;
        chk("latency s_cyc in request cycle", {28'h0, s_cyc[0]}, 32'h0);
        tick();
        chk("basic read only s_cyc[1]", {28'h0, s_cyc[0]}, 32'h2);
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        tick();
        tick();

        // Table of directed transfers
        foreach (vecs[i]) begin
            xfer(0, vecs[i].m, vecs[i].adr, vecs[i].we, vecs[i].wd, ack, err, stbs, rd, wsd, wwe, ncyc);
            if (vecs[i].slv < 0) begin
                chk($sformatf("vec%0d unmapped err", i), {30'h0, ack, err}, 32'h1);
                chk($sformatf("vec%0d unmapped no stb", i), {28'h0, stbs}, 32'h0);
            end else begin
                chk($sformatf("vec%0d ack", i), {30'h0, ack, err}, 32'h2);
                chk($sformatf("vec%0d stb", i), {28'h0, stbs}, 32'h1 << vecs[i].slv);
                if (vecs[i].we) chk($sformatf("vec%0d wdata", i), wsd, vecs[i].wd);
                else chk($sformatf("vec%0d rdata", i), rd, vecs[i].rd);
            end
            chk($sformatf("vec%0d latency", i), ncyc, 2);
        end

        // Unmapped strobe held: err once, gap, then again for the next strobe
        m_adr[0][31:0] = 32'h80000000; m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        tick();
        chk("unmapped cyc1 err", {30'h0, m_err[0]}, 32'h0);
        tick();
        chk("unmapped cyc2 err", {30'h0, m_err[0]}, 32'h1);
        tick();
        chk("unmapped cyc3 err", {30'h0, m_err[0]}, 32'h0);
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        tick();

        // Randomized transfers against the reference decode
        for (int it = 0; it < 40; it++) begin
            m = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: a = 32'h40000000 | ($urandom & 32'h1FFFFFFF);
                1: a = $urandom & 32'h0001FFFF;
                2: a = 32'hF0000000 | ($urandom & 32'hFFFF);
                3: a = 32'hF0010000 | ($urandom & 32'hFFFF);
                default: a = $urandom;
            endcase
            wd = $urandom;
            k = ref_decode(a);
            xfer(0, m, a, 1'(($urandom & 1)), wd, ack, err, stbs, rd, wsd, wwe, ncyc);
            if (k < 0) begin
                chk($sformatf("rand%0d err adr=%h", it, a), {28'h0, stbs, ack, err}, 32'h1);
            end else begin
                chk($sformatf("rand%0d ack adr=%h", it, a), {28'h0, stbs, ack, err},
                    {28'h0, 4'(1 << k), 2'b10});
                if (wwe) chk($sformatf("rand%0d wdata", it), wsd, wd);
                else chk($sformatf("rand%0d rdata", it), rd, slave_data(k, a));
            end
        end

        // Contention: both masters, single-beat cycles, on both instances
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_adr[d] = {32'h00000200, 32'h00000100};
            m_cyc[d] = 2'b11; m_stb[d] = 2'b11;
        end
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int d = 0; d < 2; d++)
                for (int j = 0; j < 2; j++) begin
                    if (m_ack[d][j]) begin
                        order[d].push_back(j);
                        m_cyc[d][j] = 1'b0; m_stb[d][j] = 1'b0;
                    end else if (!m_cyc[d][j]) begin
                        m_cyc[d][j] = 1'b1; m_stb[d][j] = 1'b1;
                    end
                end
            if (order[0].size() >= 4 && order[1].size() >= 4) break;
        end
        m_cyc = '0; m_stb = '0;
        tick();
        tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rr grant%0d", g), (order[0].size() > g) ? order[0][g] : 99, g % 2);
            chk($sformatf("fixed grant%0d", g), (order[1].size() > g) ? order[1][g] : 99, 0);
        end

        // Burst lock: M1 holds cyc over 4 strobes while M0 waits
        do_reset();
        m_adr[0][63:32] = 32'hF0010000; m_cyc[0][1] = 1'b1; m_stb[0][1] = 1'b1;
        tick();
        m_adr[0][31:0] = 32'h20; m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        bad = 0; beats = 0;
        for (int c = 0; c < 30 && beats < 4; c++) begin
            if (m_ack[0][0] || m_err[0][0] || s_cyc[0] != 4'b1000) bad++;
            if (m_ack[0][1]) begin
                beats++;
                m_adr[0][63:32] = m_adr[0][63:32] + 32'h4;
            end
            if (beats < 4) tick();
        end
        chk("burst beats", beats, 4);
        chk("burst M0 blocked", bad, 0);
        m_cyc[0][1] = 1'b0; m_stb[0][1] = 1'b0;
        tick();
        chk("burst idle gap s_cyc", {28'h0, s_cyc[0]}, 32'h0);
        tick();
        chk("burst M0 granted s_cyc", {28'h0, s_cyc[0]}, 32'h2);
        chk("burst M0 granted s_adr", s_adr[0], 32'h20);
        tick();
        chk("burst M0 ack", {30'h0, m_ack[0]}, 32'h1);
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        tick();

        // Timeout: slave 2 silent, then a response in the expiry cycle
        mute = 4'b0100;
        for (int pass = 0; pass < 2; pass++) begin
            m_adr[0][31:0] = 32'hF0000000; m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
            tick();
            bad = 0;
            for (int n = 1; n <= 8; n++) begin
                if (!s_stb[0][2] || m_err[0][0] || m_ack[0][0]) bad++;
                tick();
            end
            chk($sformatf("timeout%0d strobe cycles", pass), bad, 0);
            chk($sformatf("timeout%0d s_stb forced low", pass), {28'h0, s_stb[0]}, 32'h0);
            if (pass == 0) begin
                chk("timeout err/ack", {30'h0, m_ack[0][0], m_err[0][0]}, 32'h1);
            end else begin
                force_ack = 1'b1;
                #1;
                chk("timeout ack precedence", {30'h0, m_ack[0][0], m_err[0][0]}, 32'h2);
                force_ack = 1'b0;
            end
            m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
            tick();
            tick();
        end
        mute = '0;

        // Reset mid-write: M1 granted (pointer is 1 here), then reset
        m_adr[0][63:32] = 32'h40000010; m_dat[0][63:32] = 32'h55AA55AA;
        m_we[0][1] = 1'b1; m_cyc[0][1] = 1'b1; m_stb[0][1] = 1'b1;
        tick();
        chk("midwrite s_cyc before reset", {27'h0, s_cyc[0], s_we[0]}, 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midwrite s_cyc/s_stb during reset", {24'h0, s_cyc[0], s_stb[0]}, 32'h0);
        m_cyc[0] = '0; m_stb[0] = '0; m_we[0] = '0;
        tick();
        reset_n = 1'b1;
        m_adr[0] = {32'h40000020, 32'h00000030};
        m_cyc[0] = 2'b11; m_stb[0] = 2'b11;
        tick();
        chk("post-reset M0 first s_adr", s_adr[0], 32'h30);
        chk("post-reset M0 first s_cyc", {28'h0, s_cyc[0]}, 32'h2);
        m_cyc[0] = '0; m_stb[0] = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
